// File: rtl/aes_gcm_pkg.sv
// AES-GCM shared types, S-box and round primitives.
// State bytes are big-endian: byte i is bits [8i +: 8] of block_t; column c is bytes 4c..4c+3.
package aes_gcm_pkg;

   typedef logic [0:127] block_t;

   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic int AES_KEY_W(input int rounds);
      return 128 * (rounds + 1);
   endfunction

   function automatic logic [7:0] fn_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic block_t fn_sub_bytes(input block_t s);
      block_t r;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = SBOX[{s[8*i +: 8], 3'b000} +: 8];
      end
      return r;
   endfunction

   // Row r of column c takes the byte from column (c + r) mod 4.
   function automatic block_t fn_shift_rows(input block_t s);
      block_t r;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) begin
            r[8*(4*c + w) +: 8] = s[8*(4*((c + w) & 3) + w) +: 8];
         end
      end
      return r;
   endfunction

   function automatic block_t fn_mix_columns(input block_t s);
      block_t     r;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c      +: 8];
         a1 = s[32*c + 8  +: 8];
         a2 = s[32*c + 16 +: 8];
         a3 = s[32*c + 24 +: 8];
         r[32*c      +: 8] = fn_xtime(a0) ^ fn_xtime(a1) ^ a1 ^ a2 ^ a3;
         r[32*c + 8  +: 8] = a0 ^ fn_xtime(a1) ^ fn_xtime(a2) ^ a2 ^ a3;
         r[32*c + 16 +: 8] = a0 ^ a1 ^ fn_xtime(a2) ^ fn_xtime(a3) ^ a3;
         r[32*c + 24 +: 8] = fn_xtime(a0) ^ a0 ^ a1 ^ a2 ^ fn_xtime(a3);
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_round_unit.sv
// Single combinational AES round; the round index selects initial, middle, final or no-op behaviour.
// Purely combinational, no handshake.
module aes_round_unit
   import aes_gcm_pkg::*;
#(
   parameter int NUM_ROUNDS = 10
) (
   input  block_t     blk_in,
   input  block_t     round_key,
   input  logic [4:0] round_idx,
   output block_t     blk_out
);

   localparam logic [4:0] NR = 5'(NUM_ROUNDS);

   always_comb begin
      blk_out = blk_in;
      if (round_idx == 5'd0) begin
         blk_out = blk_in ^ round_key;
      end else if (round_idx < NR) begin
         blk_out = fn_mix_columns(fn_shift_rows(fn_sub_bytes(blk_in))) ^ round_key;
      end else if (round_idx == NR) begin
         blk_out = fn_shift_rows(fn_sub_bytes(blk_in)) ^ round_key;
      end
   end

endmodule

// File: rtl/aes_gcm_round_stage.sv
// AES-GCM round stage: rounds computed on the input side, 1-cycle latency into an output register with a
// one-entry skid buffer for full throughput under backpressure. Stats counters under AES_GCM_STAGE_STATS_EN.
module aes_gcm_round_stage
   import aes_gcm_pkg::*;
#(
   parameter int                     NUM_LANES        = 3,
   parameter int                     NUM_ROUNDS       = 10,
   parameter int                     ROUNDS_PER_STAGE = 1,
   parameter logic [4*NUM_LANES-1:0] LANE_ROUND_START = {4'd5, 4'd3, 4'd3},
   parameter int                     SIDEBAND_W       = 385,
   parameter int                     KEY_W            = AES_KEY_W(NUM_ROUNDS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic [NUM_LANES*128-1:0] i_lane_data,
   input  logic [NUM_LANES-1:0]     i_lane_en,
   input  logic [KEY_W-1:0]         i_key_schedule,
   input  logic [SIDEBAND_W-1:0]    i_sideband,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [NUM_LANES*128-1:0] o_lane_data,
   output logic [NUM_LANES-1:0]     o_lane_en,
   output logic [KEY_W-1:0]         o_key_schedule,
   output logic [SIDEBAND_W-1:0]    o_sideband,
   output logic [31:0]              o_beat_count,
   output logic [31:0]              o_stall_count
);

   typedef struct packed {
      logic [NUM_LANES*128-1:0] lane_data;
      logic [NUM_LANES-1:0]     lane_en;
      logic [KEY_W-1:0]         key_schedule;
      logic [SIDEBAND_W-1:0]    sideband;
   } beat_t;

   logic [NUM_LANES*128-1:0] nxt_lane_dat;
   beat_t                    nxt_beat;
   beat_t                    or_beat;
   beat_t                    sk_beat;
   logic                     or_vld;
   logic                     sk_vld;
   logic                     accept;
   logic                     drain;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      block_t stage_blk [0:ROUNDS_PER_STAGE];
      assign stage_blk[0] = i_lane_data[128*l +: 128];

      for (genvar k = 0; k < ROUNDS_PER_STAGE; k++) begin : g_rnd
         localparam int RIDX = int'(LANE_ROUND_START[4*l +: 4]) + k;
         block_t rkey;
         // Rounds beyond the key size have no key and degenerate to a pass-through.
         if (RIDX <= NUM_ROUNDS) begin : g_key
            assign rkey = i_key_schedule[128*RIDX +: 128];
         end else begin : g_nokey
            assign rkey = '0;
         end
         aes_round_unit #(
            .NUM_ROUNDS(NUM_ROUNDS)
         ) u_round (
            .blk_in   (stage_blk[k]),
            .round_key(rkey),
            .round_idx(5'(RIDX)),
            .blk_out  (stage_blk[k+1])
         );
      end

      assign nxt_lane_dat[128*l +: 128] = i_lane_en[l] ? stage_blk[ROUNDS_PER_STAGE]
                                                       : i_lane_data[128*l +: 128];
   end

   always_comb begin
      nxt_beat              = '0;
      nxt_beat.lane_data    = nxt_lane_dat;
      nxt_beat.lane_en      = i_lane_en;
      nxt_beat.key_schedule = i_key_schedule;
      nxt_beat.sideband     = i_sideband;
   end

   assign accept = i_in_valid && !sk_vld;
   assign drain  = or_vld && i_out_ready;

   // SK only fills while OR is stalled, so OR always holds the older beat and refills from SK first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         or_vld  <= 1'b0;
         sk_vld  <= 1'b0;
         or_beat <= '0;
         sk_beat <= '0;
      end else if (drain || !or_vld) begin
         if (sk_vld) begin
            or_beat <= sk_beat;
            or_vld  <= 1'b1;
            sk_vld  <= 1'b0;
         end else if (accept) begin
            or_beat <= nxt_beat;
            or_vld  <= 1'b1;
         end else begin
            or_vld  <= 1'b0;
         end
      end else if (accept) begin
         sk_beat <= nxt_beat;
         sk_vld  <= 1'b1;
      end
   end

   assign o_in_ready     = !sk_vld;
   assign o_out_valid    = or_vld;
   assign o_lane_data    = or_beat.lane_data;
   assign o_lane_en      = or_beat.lane_en;
   assign o_key_schedule = or_beat.key_schedule;
   assign o_sideband     = or_beat.sideband;

`ifdef AES_GCM_STAGE_STATS_EN
   logic [31:0] beat_cnt;
   logic [31:0] stall_cnt;

   // Beat count wraps; stall count saturates so a long stall never reads as a short one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (accept) begin
            beat_cnt <= beat_cnt + 32'd1;
         end
         if (or_vld && !i_out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   assign o_beat_count  = beat_cnt;
   assign o_stall_count = stall_cnt;
`else
   assign o_beat_count  = '0;
   assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_aes_gcm_round_stage.sv
// Directed bench: FIPS-197 C.1 vectors through a 2-round stage and an 11-stage chain, plus handshake,
// reset and counter checks.
module tb_aes_gcm_round_stage;

   localparam logic [127:0] PT       = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] R2_START = 128'h89d810e8855ace682d1843d8cb128fe4;
   localparam logic [127:0] R10_IN   = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
   localparam logic [127:0] CT       = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] LX       = 128'hdeadbeef0123456789abcdefcafef00d;
   localparam logic [127:0] SBW      = 128'h0123456789abcdeffedcba9876543210;

`ifdef AES_GCM_STAGE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [1407:0] key_v;

   logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [383:0]  a_lane_data, a_out_data;
   logic [2:0]    a_lane_en, a_out_en;
   logic [1407:0] a_out_key;
   logic [384:0]  a_sb, a_out_sb;
   logic [31:0]   a_bc, a_sc;

   aes_gcm_round_stage #(
      .NUM_LANES(3), .NUM_ROUNDS(10), .ROUNDS_PER_STAGE(2),
      .LANE_ROUND_START(12'hAB0), .SIDEBAND_W(385)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
      .i_lane_data(a_lane_data), .i_lane_en(a_lane_en),
      .i_key_schedule(key_v), .i_sideband(a_sb),
      .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
      .o_lane_data(a_out_data), .o_lane_en(a_out_en),
      .o_key_schedule(a_out_key), .o_sideband(a_out_sb),
      .o_beat_count(a_bc), .o_stall_count(a_sc)
   );

   logic          c_vld, c_out_rdy;
   logic [255:0]  c_dat;
   logic [1:0]    c_en;
   logic [7:0]    c_sb;
   logic          ch_vld [0:11];
   logic          ch_rdy [0:11];
   logic [255:0]  ch_dat [0:11];
   logic [1:0]    ch_en  [0:11];
   logic [1407:0] ch_key [0:11];
   logic [7:0]    ch_sb  [0:11];
   logic [31:0]   ch_bc  [0:10];
   logic [31:0]   ch_sc  [0:10];

   assign ch_vld[0]  = c_vld;
   assign ch_dat[0]  = c_dat;
   assign ch_en[0]   = c_en;
   assign ch_key[0]  = key_v;
   assign ch_sb[0]   = c_sb;
   assign ch_rdy[11] = c_out_rdy;

   for (genvar g = 0; g < 11; g++) begin : g_chain
      aes_gcm_round_stage #(
         .NUM_LANES(2), .NUM_ROUNDS(10), .ROUNDS_PER_STAGE(1),
         .LANE_ROUND_START(8'(g * 17)), .SIDEBAND_W(8)
      ) u_stage (
         .clk(clk), .rst_n(rst_n),
         .i_in_valid(ch_vld[g]), .o_in_ready(ch_rdy[g]),
         .i_lane_data(ch_dat[g]), .i_lane_en(ch_en[g]),
         .i_key_schedule(ch_key[g]), .i_sideband(ch_sb[g]),
         .o_out_valid(ch_vld[g+1]), .i_out_ready(ch_rdy[g+1]),
         .o_lane_data(ch_dat[g+1]), .o_lane_en(ch_en[g+1]),
         .o_key_schedule(ch_key[g+1]), .o_sideband(ch_sb[g+1]),
         .o_beat_count(ch_bc[g]), .o_stall_count(ch_sc[g])
      );
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic send_a(input logic [383:0] d, input logic [2:0] en, input logic [384:0] sb);
      int n;
      @(negedge clk);
      a_in_valid  = 1'b1;
      a_lane_data = d;
      a_lane_en   = en;
      a_sb        = sb;
      n = 0;
      while (!a_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", 128'(a_in_ready), 128'(1));
      @(posedge clk);
      #1 a_in_valid = 1'b0;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nxt;
      int dlv;
      key_v = {128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h549932d1f08557681093ed9cbe2c974e,
               128'h47438735a41c65b9e016baf4aebf7ad2, 128'h14f9701ae35fe28c440adf4d4ea9c026,
               128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
               128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
               128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
               128'h000102030405060708090a0b0c0d0e0f};
      a_in_valid = 1'b0; a_out_ready = 1'b1; a_lane_data = '0; a_lane_en = '0; a_sb = '0;
      c_vld = 1'b0; c_out_rdy = 1'b1; c_dat = '0; c_en = '0; c_sb = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_out_valid", 128'(a_out_valid), 128'(0));
      chk("rst_in_ready", 128'(a_in_ready), 128'(1));
      chk("rst_lane0", a_out_data[127:0], 128'(0));
      chk("rst_beat_count", 128'(a_bc), 128'(0));
      chk("rst_stall_count", 128'(a_sc), 128'(0));
      rst_n = 1'b1;

      // Lane 0 rounds 0-1, lane 1 rounds 11-12 (no-op), lane 2 rounds 10-11 (final round only).
      send_a({R10_IN, LX, PT}, 3'b111, {1'b1, {3{SBW}}});
      @(negedge clk);
      chk("latency_valid", 128'(a_out_valid), 128'(1));
      chk("lane0_rounds01", a_out_data[127:0], R2_START);
      chk("lane1_beyond_nr", a_out_data[255:128], LX);
      chk("lane2_final_round", a_out_data[383:256], CT);
      chk("fwd_lane_en", 128'(a_out_en), 128'(3'b111));
      chk("fwd_sideband_lo", a_out_sb[127:0], SBW);
      chk("fwd_sideband_msb", 128'(a_out_sb[384]), 128'(1));
      for (int r = 0; r < 11; r++) begin
         chk("fwd_key", a_out_key[128*r +: 128], key_v[128*r +: 128]);
      end

      send_a({R10_IN, LX, PT}, 3'b100, '0);
      @(negedge clk);
      chk("lane0_disabled", a_out_data[127:0], PT);
      chk("lane2_enabled", a_out_data[383:256], CT);
      chk("fwd_lane_en_b", 128'(a_out_en), 128'(3'b100));

      send_a({R10_IN, LX, PT}, 3'b011, '0);
      @(negedge clk);
      chk("lane0_enabled", a_out_data[127:0], R2_START);
      chk("lane2_disabled", a_out_data[383:256], R10_IN);

      // Counters: 5 accepted beats then 3 stalled cycles.
      reset_pulse();
      a_lane_en = 3'b111; a_out_ready = 1'b1; a_in_valid = 1'b1;
      repeat (5) @(negedge clk);
      a_in_valid = 1'b0; a_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("stats_beats", 128'(a_bc), STATS ? 128'(5) : 128'(0));
      chk("stats_stalls", 128'(a_sc), STATS ? 128'(3) : 128'(0));

      // Backpressure: 8 sequenced beats, downstream stalled at edges 3..6.
      reset_pulse();
      a_lane_data = {R10_IN, LX, PT};
      nxt = 0;
      dlv = 0;
      for (int k = 0; k < 20; k++) begin
         a_out_ready = !(k >= 3 && k <= 6);
         a_in_valid  = (nxt < 8);
         a_sb        = 385'(nxt);
         chk("bp_in_ready", 128'(a_in_ready), (k >= 4 && k <= 7) ? 128'(0) : 128'(1));
         if (k >= 4 && k <= 7) begin
            chk("bp_two_held", 128'({a_out_valid, a_in_ready}), 128'(2'b10));
         end
         if (a_out_valid && a_out_ready) begin
            chk("bp_order", 128'(a_out_sb[7:0]), 128'(dlv));
            chk("bp_data", a_out_data[127:0], R2_START);
            dlv++;
         end
         if (a_in_valid && a_in_ready) begin
            nxt++;
         end
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      chk("bp_delivered", 128'(dlv), 128'(8));
      chk("bp_stats_beats", 128'(a_bc), STATS ? 128'(8) : 128'(0));
      chk("bp_stats_stalls", 128'(a_sc), STATS ? 128'(4) : 128'(0));

      // Fill OR and SK, then reset mid-cycle.
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_sb        = 385'(8'h77);
      repeat (2) @(negedge clk);
      a_in_valid = 1'b0;
      chk("full_out_valid", 128'(a_out_valid), 128'(1));
      chk("full_in_ready", 128'(a_in_ready), 128'(0));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 128'(a_out_valid), 128'(0));
      chk("arst_in_ready", 128'(a_in_ready), 128'(1));
      chk("arst_lane0", a_out_data[127:0], 128'(0));
      chk("arst_lane2", a_out_data[383:256], 128'(0));
      chk("arst_sideband", a_out_sb[127:0], 128'(0));
      chk("arst_key", a_out_key[127:0], 128'(0));
      chk("arst_lane_en", 128'(a_out_en), 128'(0));
      chk("arst_beat_count", 128'(a_bc), 128'(0));
      chk("arst_stall_count", 128'(a_sc), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      a_out_ready = 1'b1;

      // Eleven single-round stages implement full AES-128; lane 1 disabled throughout.
      @(negedge clk);
      chk("chain_ready", 128'(ch_rdy[0]), 128'(1));
      c_vld = 1'b1; c_dat = {LX, PT}; c_en = 2'b01; c_sb = 8'h5a;
      @(posedge clk);
      #1 c_vld = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ch_vld[11] && n < 40);
      chk("chain_latency", 128'(n), 128'(11));
      chk("chain_out_valid", 128'(ch_vld[11]), 128'(1));
      chk("chain_ciphertext", ch_dat[11][127:0], CT);
      chk("chain_lane1_bypass", ch_dat[11][255:128], LX);
      chk("chain_sideband", 128'(ch_sb[11]), 128'(8'h5a));
      chk("chain_lane_en", 128'(ch_en[11]), 128'(2'b01));
      chk("chain_key10", ch_key[11][1407:1280], key_v[1407:1280]);
      chk("chain_beats", 128'(ch_bc[10]), STATS ? 128'(1) : 128'(0));
      chk("chain_stalls", 128'(ch_sc[0]), 128'(0));
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_gcm_round_stage.md
# aes_gcm_round_stage

Parametrised AES-GCM encryption pipeline stage. Applies a configurable window of AES rounds to up to NUM_LANES 128-bit blocks (H, J0, counter blocks) per beat, and carries the key schedule and an opaque sideband bundle alongside. Sits in the AES-GCM datapath between the key-expansion front end and the GHASH/XOR back end. Stages chain back-to-back through a valid/ready handshake with a skid buffer, so the pipeline sustains full throughput under backpressure.

## Interface
- NUM_LANES, 3, number of 128-bit blocks per beat
- NUM_ROUNDS, 10, AES rounds for the key size (10/12/14)
- ROUNDS_PER_STAGE, 1, rounds applied per lane in this stage (1..4)
- LANE_ROUND_START, {4'd5,4'd3,4'd3}, packed 4-bit first round per lane; lane 0 is the LSB nibble
- SIDEBAND_W, 385, width of the pass-through bundle (plain text, AAD, instance size, new-instance flag)
- KEY_W, 128*(NUM_ROUNDS+1), derived key-schedule width; not to be overridden

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_in_valid  in  1  upstream beat valid
- o_in_ready  out  1  stage can accept a beat
- i_lane_data  in  NUM_LANES*128  input blocks; lane l at [128l +: 128]
- i_lane_en  in  NUM_LANES  per-lane round enable
- i_key_schedule  in  KEY_W  round keys; key r at [128r +: 128]
- i_sideband  in  SIDEBAND_W  opaque payload
- o_out_valid  out  1  downstream beat valid
- i_out_ready  in  1  downstream accepts
- o_lane_data  out  NUM_LANES*128  processed blocks
- o_lane_en, o_key_schedule, o_sideband  out  as inputs  forwarded with the beat
- o_beat_count  out  32  accepted-beat counter (see Configuration)
- o_stall_count  out  32  stall-cycle counter (see Configuration)

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
- Accept: a beat is accepted when i_in_valid && o_in_ready. A beat is delivered when o_out_valid && i_out_ready.
- Rounds are computed combinationally on the input side and stored in the output register.
- For lane l with i_lane_en[l]=1, apply rounds r = S_l .. S_l+ROUNDS_PER_STAGE-1 in order, where S_l = LANE_ROUND_START[l]:
  - r==0: AddRoundKey only, with key 0.
  - 1 <= r < NUM_ROUNDS: SubBytes, ShiftRows, MixColumns, AddRoundKey with key r.
  - r==NUM_ROUNDS: same as above but MixColumns is omitted.
  - r>NUM_ROUNDS: no-op.
- A disabled lane passes its block through unchanged.
- The key schedule, lane enables and sideband travel unchanged with the beat.
- Storage: an output register (OR) and a one-entry skid register (SK), each with a valid bit.
  - o_in_ready = !SK.valid (registered).
  - Accepted beat goes to OR if OR is empty or is being drained this cycle; otherwise it goes to SK.
  - When OR drains and SK is valid, SK moves to OR and SK is cleared.
- Ordering: beats leave strictly in acceptance order. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge N is on o_out_valid after edge N (1 cycle) when OR is empty.
- Throughput: 1 beat/cycle while i_out_ready=1.
- Backpressure:
  - With OR full and i_out_ready=0, one more beat is absorbed into SK.
  - o_in_ready falls the following cycle and rises in the cycle after SK drains.
- Simultaneous accept and drain with SK empty: the new beat replaces OR. No bubble.
- Simultaneous accept and drain with SK full: not possible, since o_in_ready=0.
- Reset values:
  - o_out_valid=0, o_in_ready=1.
  - All data, key, sideband and lane_en outputs 0.
  - Both counters 0.
- Reset asserted mid-operation discards OR and SK contents immediately (asynchronously).

## Configuration
- AES_GCM_STAGE_STATS_EN defined:
  - o_beat_count increments on every accepted beat, wrapping at 2^32.
  - o_stall_count increments on every cycle with o_out_valid && !i_out_ready, saturating at 2^32-1.
- Not defined: both counters are tied to 0 and no counter flops are inferred.

## Structure
- Package aes_gcm_pkg holds:
  - block_t (logic [0:127])
  - S-box constant table
  - functions fn_sub_bytes, fn_shift_rows, fn_mix_columns, fn_xtime
  - AES_KEY_W(rounds) helper
- Sub-module aes_round_unit: combinational single round. Ports are block in, round key, round index, NUM_ROUNDS; output is block out. The stage instantiates NUM_LANES × ROUNDS_PER_STAGE copies.

## Test plan
- FIPS-197 C.1 vector (key 000102…0f), lane 0 with S=0, ROUNDS_PER_STAGE=2, input 00112233445566778899aabbccddeeff -> o_lane_data lane 0 = 89d810e8855ace682d1843d8cb128fe4 one cycle after accept.
- Chain 11 single-round stages, S=0..10, same vector -> final output 69c4e0d86a7b0430d8cdb78070b4c55a. Also cover i_lane_en[1]=0 -> lane 1 output equals its input bit-exactly.
- Backpressure: stream 8 beats with sequence numbers in i_sideband, i_out_ready=0 for cycles 3–6 -> exactly 2 beats held, o_in_ready=0 from cycle 4, all 8 delivered in order with no loss.
- Lane with S=11 and NUM_ROUNDS=10 -> block unchanged; lane with S=10 -> final round applied without MixColumns.
- Assert rst_n while OR and SK are full -> o_out_valid=0 and o_in_ready=1 immediately, outputs 0, counters 0.
- With AES_GCM_STAGE_STATS_EN: 5 accepted beats and 3 stalled cycles -> o_beat_count=5, o_stall_count=3. Without the macro -> both 0.
